iterative_divider: RTL and testbench

- Multi-cycle restoring shift-subtract divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Counterpart to the combinational adder: it computes by repeated subtraction and produces one quotient bit per clock.
- Sits beside the ALU; the control path stalls the core while busy_o is high and captures the results when valid_o pulses.
- Result semantics follow the RISC-V M-extension exactly, including divide-by-zero and signed overflow.

---
 rtl/iterative_divider.sv | 70 +++++++
 tb/tb_iterative_divider.sv | 127 ++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// iterative_divider: restoring shift-subtract divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle
module iterative_divider #(
  parameter int DataWidth = 32,
  localparam int CountWidth = $clog2(DataWidth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [DataWidth-1:0] dividend_i,
  input  logic [DataWidth-1:0] divisor_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [DataWidth-1:0] quotient_o,
  output logic [DataWidth-1:0] remainder_o
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [DataWidth-1:0] rem, quo, dvs, abs_a, abs_b;
  logic [DataWidth:0] trial;
  logic [CountWidth-1:0] cnt;
  logic neg_q, neg_r, sa, sb, div0, ovf, special, accept;
  always_comb begin
    accept = start_i && state != CALC;
    sa = signed_i & dividend_i[DataWidth-1];
    sb = signed_i & divisor_i[DataWidth-1];
    abs_a = sa ? -dividend_i : dividend_i;
    abs_b = sb ? -divisor_i : divisor_i;
    div0 = divisor_i == '0;
    ovf = signed_i && dividend_i == {1'b1, {(DataWidth-1){1'b0}}} && &divisor_i;
    special = div0 | ovf;
    trial = {rem, quo[DataWidth-1]} - {1'b0, dvs};
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = accept ? CALC : state == CALC ? (cnt == '0 ? DONE : CALC) : IDLE;
  always_comb begin
    busy_o = state == CALC;
    valid_o = state == DONE;
  end
  // Special cases preload their final result with cnt = 0 so CALC hands it straight to DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quotient_o <= '0;
      remainder_o <= '0;
    end else if (accept) begin
      quo <= div0 ? '1 : ovf ? dividend_i : abs_a;
      rem <= div0 ? dividend_i : '0;
      dvs <= abs_b;
      cnt <= special ? '0 : CountWidth'(DataWidth);
      neg_q <= !special & (sa ^ sb);
      neg_r <= !special & sa;
    end else if (state == CALC && cnt != '0) begin
      rem <= trial[DataWidth] ? {rem[DataWidth-2:0], quo[DataWidth-1]} : trial[DataWidth-1:0];
      quo <= {quo[DataWidth-2:0], ~trial[DataWidth]};
      cnt <= cnt - CountWidth'(1);
    end else if (state == CALC) begin
      quotient_o <= neg_q ? -quo : quo;
      remainder_o <= neg_r ? -rem : rem;
    end
  end
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: directed RV32M divider vectors with hand-computed results and latency checks
module tb_iterative_divider;
  logic clk = 0, rst_i = 0, start_i = 0, signed_i = 0;
  logic [31:0] dividend_i = 0, divisor_i = 0, quotient_o, remainder_o;
  logic busy_o, valid_o;
  int total = 0, bad = 0;
  iterative_divider dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .busy_o(busy_o),
    .valid_o(valid_o), .quotient_o(quotient_o), .remainder_o(remainder_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask
  task automatic go(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_i = s;
    dividend_i = a;
    divisor_i = b;
    start_i = 1;
    @(posedge clk);
    #1 start_i = 0;
    dividend_i = 32'hDEADBEEF;
    divisor_i = 0;
  endtask
  task automatic wait_res(input string tag, input logic [31:0] eq, input logic [31:0] er,
                          input int elat, input int poke);
    int n, nb;
    bit got;
    n = 0;
    nb = 0;
    got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (valid_o) got = 1;
      else begin
        nb += int'(busy_o);
        n++;
      end
      if (!got && n == poke) begin
        start_i = 1;
        signed_i = 0;
        dividend_i = 9;
        divisor_i = 3;
      end else start_i = 0;
    end
    chk({tag, ".lat"}, 32'(n), 32'(elat));
    chk({tag, ".busy_cycles"}, 32'(nb), 32'(elat));
    chk({tag, ".busy_at_valid"}, 32'(busy_o), 0);
    chk({tag, ".q"}, quotient_o, eq);
    chk({tag, ".r"}, remainder_o, er);
  endtask
  task automatic once(input string tag);
    @(negedge clk);
    chk({tag, ".valid_once"}, 32'(valid_o), 0);
  endtask
  initial begin
    int nv;
    #2 rst_i = 1;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy_o), 0);
    chk("rst.valid", 32'(valid_o), 0);
    chk("rst.q", quotient_o, 0);
    chk("rst.r", remainder_o, 0);
    rst_i = 0;
    @(negedge clk);
    go(0, 100, 7);
    wait_res("divu100_7", 14, 2, 33, -1);
    once("divu100_7");
    go(0, 100, 7);
    wait_res("mid_start", 14, 2, 33, 10);
    once("mid_start");
    go(0, 100, 7);
    repeat (10) @(negedge clk);
    rst_i = 1;
    #1;
    chk("arst.busy", 32'(busy_o), 0);
    chk("arst.valid", 32'(valid_o), 0);
    chk("arst.q", quotient_o, 0);
    chk("arst.r", remainder_o, 0);
    @(negedge clk);
    rst_i = 0;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      nv += int'(valid_o);
    end
    chk("arst.no_valid", 32'(nv), 0);
    go(0, 100, 7);
    wait_res("post_rst", 14, 2, 33, -1);
    once("post_rst");
    go(1, 32'hFFFFFFF9, 2);
    wait_res("div_m7_2", 32'hFFFFFFFD, 32'hFFFFFFFF, 33, -1);
    once("div_m7_2");
    go(1, 7, 32'hFFFFFFFE);
    wait_res("div_7_m2", 32'hFFFFFFFD, 1, 33, -1);
    go(1, 32'hFFFFFFF9, 32'hFFFFFFFE);
    wait_res("div_m7_m2", 3, 32'hFFFFFFFF, 33, -1);
    @(negedge clk);
    go(0, 5, 0);
    wait_res("divu5_0", 32'hFFFFFFFF, 5, 1, -1);
    once("divu5_0");
    go(1, 32'hFFFFFFFB, 0);
    wait_res("div_m5_0", 32'hFFFFFFFF, 32'hFFFFFFFB, 1, -1);
    once("div_m5_0");
    go(1, 32'h80000000, 32'hFFFFFFFF);
    wait_res("div_ovf", 32'h80000000, 0, 1, -1);
    once("div_ovf");
    go(0, 32'hFFFFFFFF, 1);
    wait_res("divu_max_1", 32'hFFFFFFFF, 0, 33, -1);
    once("divu_max_1");
    go(0, 3, 32'hFFFFFFFF);
    wait_res("divu_3_max", 0, 3, 33, -1);
    once("divu_3_max");
    go(0, 100, 7);
    wait_res("b2b_first", 14, 2, 33, -1);
    go(0, 9, 3);
    wait_res("b2b_second", 3, 0, 33, -1);
    once("b2b_second");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
